uart_rx_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_engine.sv | 124 ++++++++++++
 rtl/uart_tx_engine.sv | 109 ++++++++++
 rtl/uart_rx_tx.sv | 38 +++
 tb/tb_uart_rx_tx.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART: FSM state encodings, default bit timing
// and frame geometry.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 87;
  localparam int DATA_BITS            = 8;
  localparam int STOP_BITS            = 1;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP,
    TX_CLEANUP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_CLEANUP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_engine.sv
// Receive engine: synchronises the line, qualifies the start bit at mid-bit and
// samples each following bit one bit time later.
module uart_rx_engine
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_serial,
  output logic                 rx_dv,
  output logic [DATA_BITS-1:0] rx_byte
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_BIT = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  rx_state_t            state, state_next;
  logic                 rx_meta, rx_sync;
  logic [CW-1:0]        clk_cnt, clk_cnt_next;
  logic [IW-1:0]        bit_idx, bit_idx_next;
  logic [DATA_BITS-1:0] shift, shift_next;
  logic [DATA_BITS-1:0] byte_next;
  logic                 frame_err, frame_err_next;
  logic                 dv_next;

  // Two-flop synchroniser resets to the idle-high line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx_serial;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RX_IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      frame_err <= 1'b0;
      rx_dv     <= 1'b0;
      rx_byte   <= '0;
    end else begin
      state     <= state_next;
      clk_cnt   <= clk_cnt_next;
      bit_idx   <= bit_idx_next;
      shift     <= shift_next;
      frame_err <= frame_err_next;
      rx_dv     <= dv_next;
      rx_byte   <= byte_next;
    end
  end

  always_comb begin
    state_next     = state;
    clk_cnt_next   = clk_cnt;
    bit_idx_next   = bit_idx;
    shift_next     = shift;
    frame_err_next = frame_err;
    byte_next      = rx_byte;
    dv_next        = 1'b0;

    case (state)
      RX_IDLE: begin
        clk_cnt_next = '0;
        bit_idx_next = '0;
        if (!rx_sync) state_next = RX_START;
      end
      RX_START: begin
        if (clk_cnt == HALF_BIT) begin
          clk_cnt_next = '0;
          state_next   = rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          clk_cnt_next = clk_cnt + CW'(1);
        end
      end
      RX_DATA: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_next        = '0;
          shift_next[bit_idx] = rx_sync;
          if (bit_idx == IDX_LAST) begin
            bit_idx_next = '0;
            state_next   = RX_STOP;
          end else begin
            bit_idx_next = bit_idx + IW'(1);
          end
        end else begin
          clk_cnt_next = clk_cnt + CW'(1);
        end
      end
      RX_STOP: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_next = '0;
          state_next   = RX_CLEANUP;
          if (rx_sync) begin
            byte_next      = shift;
            dv_next        = 1'b1;
            frame_err_next = 1'b0;
          end else begin
            frame_err_next = 1'b1;
          end
        end else begin
          clk_cnt_next = clk_cnt + CW'(1);
        end
      end
      RX_CLEANUP: begin
        // After a bad stop bit, a line still held low must not look like a new start.
        if (!frame_err || rx_sync) begin
          frame_err_next = 1'b0;
          state_next     = RX_IDLE;
        end
      end
      default: state_next = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_tx_engine.sv
// Transmit engine: serialises one latched byte as start, 8 data bits LSB first,
// and a stop bit. Outputs are registered, so the line follows the state by one cycle.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_dv,
  input  logic [DATA_BITS-1:0] tx_byte,
  output logic                 tx_serial,
  output logic                 tx_active,
  output logic                 tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  tx_state_t            state, state_next;
  logic [CW-1:0]        clk_cnt, clk_cnt_next;
  logic [IW-1:0]        bit_idx, bit_idx_next;
  logic [DATA_BITS-1:0] data, data_next;
  logic                 serial_next, active_next, done_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= TX_IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      data      <= '0;
      tx_serial <= 1'b1;
      tx_active <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_next;
      clk_cnt   <= clk_cnt_next;
      bit_idx   <= bit_idx_next;
      data      <= data_next;
      tx_serial <= serial_next;
      tx_active <= active_next;
      tx_done   <= done_next;
    end
  end

  always_comb begin
    state_next   = state;
    clk_cnt_next = clk_cnt;
    bit_idx_next = bit_idx;
    data_next    = data;
    serial_next  = 1'b1;
    active_next  = 1'b0;
    done_next    = 1'b0;

    case (state)
      TX_IDLE: begin
        clk_cnt_next = '0;
        bit_idx_next = '0;
        // Only IDLE looks at the request, so a busy engine neither queues it nor reloads data.
        if (tx_dv) begin
          data_next  = tx_byte;
          state_next = TX_START;
        end
      end
      TX_START: begin
        serial_next = 1'b0;
        active_next = 1'b1;
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_next = '0;
          state_next   = TX_DATA;
        end else begin
          clk_cnt_next = clk_cnt + CW'(1);
        end
      end
      TX_DATA: begin
        serial_next = data[bit_idx];
        active_next = 1'b1;
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_next = '0;
          if (bit_idx == IDX_LAST) begin
            bit_idx_next = '0;
            state_next   = TX_STOP;
          end else begin
            bit_idx_next = bit_idx + IW'(1);
          end
        end else begin
          clk_cnt_next = clk_cnt + CW'(1);
        end
      end
      TX_STOP: begin
        active_next = 1'b1;
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_next = '0;
          state_next   = TX_CLEANUP;
        end else begin
          clk_cnt_next = clk_cnt + CW'(1);
        end
      end
      TX_CLEANUP: begin
        done_next  = 1'b1;
        state_next = TX_IDLE;
      end
      default: state_next = TX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_rx_tx.sv
// 8N1 UART top: independent transmit and receive engines sharing clock, reset
// and bit timing.
module uart_rx_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Active,
  output logic       o_Tx_Done,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte
);

  uart_tx_engine #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk       (i_Clock),
    .rst_n     (i_Rst_n),
    .tx_dv     (i_Tx_DV),
    .tx_byte   (i_Tx_Byte),
    .tx_serial (o_Tx_Serial),
    .tx_active (o_Tx_Active),
    .tx_done   (o_Tx_Done)
  );

  uart_rx_engine #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (i_Clock),
    .rst_n     (i_Rst_n),
    .rx_serial (i_Rx_Serial),
    .rx_dv     (o_Rx_DV),
    .rx_byte   (o_Rx_Byte)
  );

endmodule

// File: tb/tb_uart_rx_tx.sv
// Directed-plus-random bench for uart_rx_tx; expected waveforms and bytes come
// from the 8N1 frame definition, not from the engines' internals.
module tb_uart_rx_tx;

  localparam int C      = 87;
  localparam int RX_LAT = 2 + (C - 1) / 2 + 9 * C + 1;

  logic       clk;
  logic       rst_n;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       tx_serial;
  logic       tx_active;
  logic       tx_done;
  logic       rx_serial;
  logic       rx_dv;
  logic [7:0] rx_byte;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cycle    = 0;
  int         done_cnt = 0;
  int         rx_fall  = 0;
  int         last_dv_cycle = 0;
  int         rx_exp_cnt = 0;
  logic [7:0] rx_got[$];

  uart_rx_tx #(.CLKS_PER_BIT(C)) dut (
    .i_Clock     (clk),
    .i_Rst_n     (rst_n),
    .i_Tx_DV     (tx_dv),
    .i_Tx_Byte   (tx_byte),
    .o_Tx_Serial (tx_serial),
    .o_Tx_Active (tx_active),
    .o_Tx_Done   (tx_done),
    .i_Rx_Serial (rx_serial),
    .o_Rx_DV     (rx_dv),
    .o_Rx_Byte   (rx_byte)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Every cycle with DV high is logged, so a stretched pulse shows up as an extra byte.
  always @(negedge clk) begin
    if (rx_dv) begin
      rx_got.push_back(rx_byte);
      last_dv_cycle = cycle;
    end
    if (tx_done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tx_frame(input logic [7:0] b, input bit poke);
    logic [9:0] frame;
    int         bit_err[10];
    int         act_err;
    int         done_err;
    frame    = {1'b1, b, 1'b0};
    act_err  = 0;
    done_err = 0;
    for (int i = 0; i < 10; i++) bit_err[i] = 0;
    @(negedge clk);
    tx_dv   = 1'b1;
    tx_byte = b;
    @(negedge clk);
    tx_dv   = 1'b0;
    tx_byte = 8'($urandom);
    check("tx_idle_before_start", {31'd0, tx_serial}, 32'd1);
    for (int k = 0; k < 10 * C; k++) begin
      @(negedge clk);
      if (tx_serial !== frame[k / C]) bit_err[k / C]++;
      if (tx_active !== 1'b1) act_err++;
      if (tx_done !== 1'b0) done_err++;
      if (poke && (k == 4 * C + 10)) begin
        tx_dv   = 1'b1;
        tx_byte = ~b;
      end else begin
        tx_dv = 1'b0;
      end
    end
    for (int i = 0; i < 10; i++) check($sformatf("tx_bit%0d_errcycles", i), bit_err[i], 0);
    check("tx_active_during_frame_errcycles", act_err, 0);
    check("tx_done_during_frame_errcycles", done_err, 0);
    @(negedge clk);
    check("tx_done_pulse", {31'd0, tx_done}, 32'd1);
    check("tx_active_after_frame", {31'd0, tx_active}, 32'd0);
    check("tx_serial_after_frame", {31'd0, tx_serial}, 32'd1);
    @(negedge clk);
    check("tx_done_single_cycle", {31'd0, tx_done}, 32'd0);
  endtask

  task automatic rx_frame(input logic [7:0] b, input int start_len, input logic stop_val);
    @(negedge clk);
    rx_serial = 1'b0;
    rx_fall   = cycle;
    repeat (start_len) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_serial = b[i];
      repeat (C) @(negedge clk);
    end
    rx_serial = stop_val;
    repeat (C) @(negedge clk);
    rx_serial = 1'b1;
  endtask

  task automatic expect_rx(input string tag, input logic [7:0] b);
    int diff;
    rx_exp_cnt++;
    diff = last_dv_cycle - rx_fall;
    check({tag, "_dv_count"}, rx_got.size(), rx_exp_cnt);
    check({tag, "_dv_byte"}, rx_got[$], b);
    check({tag, "_out_byte"}, rx_byte, b);
    check({tag, "_latency"}, (diff >= RX_LAT - 1 && diff <= RX_LAT + 1) ? RX_LAT : diff, RX_LAT);
  endtask

  initial begin
    logic [7:0] r;
    logic [7:0] held;
    rst_n     = 1'b0;
    tx_dv     = 1'b0;
    tx_byte   = 8'h00;
    rx_serial = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_tx_serial", {31'd0, tx_serial}, 32'd1);
    check("reset_tx_active", {31'd0, tx_active}, 32'd0);
    check("reset_tx_done", {31'd0, tx_done}, 32'd0);
    check("reset_rx_dv", {31'd0, rx_dv}, 32'd0);
    check("reset_rx_byte", rx_byte, 8'h00);

    tx_frame(8'h3F, 1'b0);
    r = 8'($urandom);
    tx_frame(r, 1'b1);

    rx_frame(8'h3F, (C * 11) / 10, 1'b1);
    repeat (10) @(negedge clk);
    expect_rx("rx_3f_long_start", 8'h3F);

    rx_frame(8'h00, C, 1'b1);
    expect_rx("rx_b2b_00", 8'h00);
    rx_frame(8'hFF, C, 1'b1);
    expect_rx("rx_b2b_ff", 8'hFF);
    for (int n = 0; n < 3; n++) begin
      r = 8'($urandom);
      rx_frame(r, C, 1'b1);
      expect_rx($sformatf("rx_rand%0d", n), r);
    end

    // Short low pulse must be rejected at the mid-start check.
    held = rx_byte;
    @(negedge clk);
    rx_serial = 1'b0;
    repeat (20) @(negedge clk);
    rx_serial = 1'b1;
    repeat (2 * C) @(negedge clk);
    check("glitch_no_dv", rx_got.size(), rx_exp_cnt);
    check("glitch_byte_held", rx_byte, held);
    rx_frame(8'hA5, C, 1'b1);
    expect_rx("rx_a5_after_glitch", 8'hA5);

    // Stop bit driven low: no DV and the previous byte stays put.
    r = 8'($urandom);
    rx_frame(r, C, 1'b0);
    repeat (2 * C) @(negedge clk);
    check("framing_err_no_dv", rx_got.size(), rx_exp_cnt);
    check("framing_err_byte_held", rx_byte, 8'hA5);
    r = 8'($urandom) | 8'h01;
    rx_frame(r, C, 1'b1);
    expect_rx("rx_after_framing_err", r);

    // Reset in the middle of a TX frame and a partial RX frame.
    @(negedge clk);
    tx_dv     = 1'b1;
    tx_byte   = 8'h81;
    rx_serial = 1'b0;
    @(negedge clk);
    tx_dv = 1'b0;
    repeat (300) @(negedge clk);
    check("mid_tx_active_before_reset", {31'd0, tx_active}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("reset_mid_tx_serial", {31'd0, tx_serial}, 32'd1);
    check("reset_mid_tx_active", {31'd0, tx_active}, 32'd0);
    check("reset_mid_rx_byte", rx_byte, 8'h00);
    rx_serial = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12 * C) @(negedge clk);
    check("reset_partial_rx_discarded", rx_got.size(), rx_exp_cnt);
    check("reset_tx_done_quiet", done_cnt, 2);

    r = 8'($urandom);
    tx_frame(r, 1'b0);
    check("tx_done_total", done_cnt, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
